fccc_clken_gen: RTL and testbench

Parametrised lock-qualified clock-enable generator on the fabric global clock driven by the FCCC (CCC macro `GL0` output, `LOCK` status). It filters the asynchronous PLL `LOCK`, holds downstream logic in reset until lock has been stable, then produces `NUM_CH` independently divided, phase-offset clock-enable pulses. Loss of lock re-asserts reset and counts the event. One generator serves the whole clock domain; downstream logic uses `CE` instead of extra CCC outputs.

---
 rtl/fccc_pkg.sv | 22 ++
 rtl/fccc_ce_div.sv | 43 ++++
 rtl/fccc_clken_gen.sv | 116 +++++++++++
 tb/tb_fccc_clken_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fccc_pkg.sv
// Shared types and helpers for the FCCC lock-qualified clock-enable generator.
package fccc_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_FILTER    = 2'd1,
    ST_RUN       = 2'd2,
    ST_LOST      = 2'd3
  } fccc_state_t;

  localparam int LOSS_CNT_W = 8;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fccc_ce_div.sv
// One clock-enable channel: phase-loaded down-counter, CE when it reaches zero.
// Zero latency from counter to CE; DIV is picked up only at wrap, PHASE only at load.
module fccc_ce_div #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_run,
  input  logic             i_active,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  input  logic [DIV_W-1:0] i_phase,
  output logic             o_ce
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_n_m1;
  logic [DIV_W-1:0] w_phase;

  // A divide of 0 behaves as 1, so N-1 is 0 in both cases.
  always_comb begin
    w_n_m1  = (i_div == '0) ? '0 : i_div - ONE;
    w_phase = (i_phase > w_n_m1) ? w_n_m1 : i_phase;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= w_phase;
    end else if (i_run) begin
      r_cnt <= (r_cnt == '0) ? w_n_m1 : r_cnt - ONE;
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_ce = i_active & i_en & (r_cnt == '0);

endmodule

// File: rtl/fccc_clken_gen.sv
// Lock-qualified reset release and NUM_CH divided clock-enables on the CCC GL0 domain.
// READY rises LOCK_FILTER+2 edges after lock is first sampled; drops 2 edges after loss.
module fccc_clken_gen
  import fccc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_FILTER = 1024
) (
  input  logic                    CLK0,
  input  logic                    ARST_N,
  input  logic                    LOCK,
  input  logic [NUM_CH*DIV_W-1:0] DIV,
  input  logic [NUM_CH*DIV_W-1:0] PHASE,
  input  logic [NUM_CH-1:0]       EN,
  output logic                    READY,
  output logic                    RST_OUT_N,
  output logic [NUM_CH-1:0]       CE,
  output logic [LOSS_CNT_W-1:0]   LOSS_CNT
);

  localparam int                   FILT_W    = clog2(LOCK_FILTER);
  localparam logic [FILT_W-1:0]    FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [FILT_W-1:0]    FILT_ONE  = FILT_W'(1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_ONE = LOSS_CNT_W'(1);

  logic [1:0]            r_rst_sync;
  logic                  w_rst_n;
  logic                  r_lock_meta;
  logic                  r_lock_s;
  fccc_state_t           r_state;
  logic [FILT_W-1:0]     r_filt_cnt;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;
  logic                  r_ready;
  logic                  w_enter_run;
  logic                  w_stay_run;

  // Reset asserts asynchronously, releases two CLK0 edges later.
  always_ff @(posedge CLK0 or negedge ARST_N) begin
    if (!ARST_N) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge CLK0 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= LOCK;
      r_lock_s    <= r_lock_meta;
    end
  end

  always_ff @(posedge CLK0 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= ST_WAIT_LOCK;
      r_filt_cnt <= '0;
      r_loss_cnt <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          r_filt_cnt <= '0;
          r_ready    <= 1'b0;
          if (r_lock_s) r_state <= ST_FILTER;
        end
        ST_FILTER: begin
          if (!r_lock_s) begin
            r_state <= ST_WAIT_LOCK;
          end else if (r_filt_cnt == FILT_LAST) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end else begin
            r_filt_cnt <= r_filt_cnt + FILT_ONE;
          end
        end
        ST_RUN: begin
          if (!r_lock_s) begin
            r_state <= ST_LOST;
            r_ready <= 1'b0;
            if (r_loss_cnt != '1) r_loss_cnt <= r_loss_cnt + LOSS_ONE;
          end
        end
        default: begin
          r_state <= ST_WAIT_LOCK;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign w_enter_run = (r_state == ST_FILTER) && r_lock_s && (r_filt_cnt == FILT_LAST);
  assign w_stay_run  = (r_state == ST_RUN) && r_lock_s;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    fccc_ce_div #(
      .DIV_W (DIV_W)
    ) u_div (
      .i_clk    (CLK0),
      .i_rst_n  (w_rst_n),
      .i_load   (w_enter_run),
      .i_run    (w_stay_run),
      .i_active (r_ready),
      .i_en     (EN[gi]),
      .i_div    (DIV[gi*DIV_W +: DIV_W]),
      .i_phase  (PHASE[gi*DIV_W +: DIV_W]),
      .o_ce     (CE[gi])
    );
  end

  assign READY     = r_ready;
  assign RST_OUT_N = r_ready;
  assign LOSS_CNT  = r_loss_cnt;

endmodule

// File: tb/tb_fccc_clken_gen.sv
// Directed bench for fccc_clken_gen: expected outputs are queued per cycle, a monitor checks them.
module tb_fccc_clken_gen;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        lock;
  logic [31:0] div;
  logic [31:0] phase;
  logic [3:0]  en;
  logic        ready;
  logic        rst_out_n;
  logic [3:0]  ce;
  logic [7:0]  loss_cnt;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int         cyc;
    logic       rdy;
    logic [3:0] ce;
    logic [3:0] msk;
    logic [7:0] loss;
    logic       chk;
  } exp_t;

  exp_t  sb[$];
  string sb_nm[$];

  fccc_clken_gen #(
    .NUM_CH      (4),
    .DIV_W       (8),
    .LOCK_FILTER (8)
  ) dut (
    .CLK0      (clk),
    .ARST_N    (arst_n),
    .LOCK      (lock),
    .DIV       (div),
    .PHASE     (phase),
    .EN        (en),
    .READY     (ready),
    .RST_OUT_N (rst_out_n),
    .CE        (ce),
    .LOSS_CNT  (loss_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input string nm, input logic r, input logic [3:0] c_e,
                      input logic [3:0] m, input logic [7:0] l, input logic chk);
    exp_t e;
    int   k;
    e.cyc = c; e.rdy = r; e.ce = c_e; e.msk = m; e.loss = l; e.chk = chk;
    k = sb.size();
    while (k > 0 && sb[k-1].cyc > c) k--;
    sb.insert(k, e);
    sb_nm.insert(k, nm);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e  = sb.pop_front();
      nm = sb_nm.pop_front();
      total++;
      if (e.cyc < cyc || ready !== e.rdy || rst_out_n !== e.rdy ||
          (ce & e.msk) !== (e.ce & e.msk) || (e.chk && loss_cnt !== e.loss)) begin
        bad++;
        $display("FAIL %s cyc=%0d/%0d got ready=%b rst_out_n=%b ce=%b loss=%0d want ready=%b ce=%b mask=%b loss=%0d chk=%b",
                 nm, cyc, e.cyc, ready, rst_out_n, ce, loss_cnt, e.rdy, e.ce, e.msk, e.loss, e.chk);
      end
    end
  end

  initial begin
    int         c, r0, r2, d, s0, t, u, w;
    logic [3:0] v;
    arst_n = 1'b0;
    lock   = 1'b1;
    div    = {8'd7, 8'd4, 8'd1, 8'd0};
    phase  = {8'd9, 8'd2, 8'd0, 8'd0};
    en     = 4'hF;
    tick(3);

    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL in_rst ready=%b", ready);
    end
    total++;
    if (rst_out_n !== 1'b0) begin
      bad++;
      $display("FAIL in_rst rst_out_n=%b", rst_out_n);
    end
    total++;
    if (ce !== 4'h0) begin
      bad++;
      $display("FAIL in_rst ce=%b", ce);
    end
    total++;
    if (loss_cnt !== 8'd0) begin
      bad++;
      $display("FAIL in_rst loss=%0d", loss_cnt);
    end

    // Release reset with LOCK already high: two sync edges, then e0..e10.
    c  = cyc;
    r0 = c + 13;
    for (int k = 1; k <= 12; k++) push(c + k, "rst_hold", 1'b0, 4'h0, 4'hF, 8'd0, 1'b1);
    for (int r = 0; r < 22; r++) begin
      v[0] = 1'b1;
      v[1] = 1'b1;
      v[2] = (r >= 2) && (((r - 2) % 4) == 0);
      v[3] = (r >= 6) && (((r - 6) % 7) == 0);
      push(r0 + r, "ce_run1", 1'b1, v, 4'hF, 8'd0, 1'b1);
    end
    arst_n = 1'b1;
    tick(35);

    // Lock loss in RUN, then re-acquire.
    d  = cyc;
    r2 = d + 16;
    push(d + 1, "loss_f1", 1'b1, 4'h0, 4'h0, 8'd0, 1'b1);
    push(d + 2, "loss_f1b", 1'b1, 4'b0011, 4'b0011, 8'd0, 1'b1);
    push(d + 3, "loss_f2", 1'b0, 4'h0, 4'hF, 8'd1, 1'b1);
    for (int k = 4; k <= 15; k++) push(d + k, "relock", 1'b0, 4'h0, 4'hF, 8'd1, 1'b1);
    push(r2, "relockup", 1'b1, 4'b0011, 4'hF, 8'd1, 1'b1);
    for (int r = 0; r < 16; r++) begin
      v    = 4'h0;
      v[2] = (r == 2) || (r == 6) || (r == 8) || (r == 12) || (r == 14);
      push(r2 + r, "div_chg", 1'b1, v, 4'b0100, 8'd1, 1'b1);
    end
    lock = 1'b0;
    tick(5);
    lock = 1'b1;
    tick(14);
    div[23:16] = 8'd2;
    tick(6);
    en[2] = 1'b0;
    tick(2);
    en[2] = 1'b1;
    tick(5);

    // 300 loss events: counter saturates.
    s0 = cyc;
    foreach (sb[i]) begin end
    for (int i = 0; i < 300; i++) begin
      if (i == 0 || i == 1 || i == 252 || i == 253 || i == 299)
        push(s0 + 17 * i + 4, "loss_sat", 1'b0, 4'h0, 4'hF,
             8'(((2 + i) > 255) ? 255 : (2 + i)), 1'b1);
      if (i == 0 || i == 299) begin
        push(s0 + 17 * i + 15, "rdy_lo", 1'b0, 4'h0, 4'hF, 8'd0, 1'b0);
        push(s0 + 17 * i + 16, "rdy_hi", 1'b1, 4'h0, 4'h0, 8'd0, 1'b0);
      end
    end
    for (int i = 0; i < 300; i++) begin
      lock = 1'b0;
      tick(5);
      lock = 1'b1;
      tick(12);
    end

    // Reset pulsed during FILTER.
    lock = 1'b0;
    tick(5);
    lock = 1'b1;
    t = cyc;
    push(t + 4, "pre_arst", 1'b0, 4'h0, 4'hF, 8'd255, 1'b1);
    push(t + 5, "arst_clr", 1'b0, 4'h0, 4'hF, 8'd0, 1'b1);
    tick(4);
    arst_n = 1'b0;
    tick(2);
    u = cyc;
    push(u + 12, "arst_lo", 1'b0, 4'h0, 4'hF, 8'd0, 1'b1);
    push(u + 13, "arst_hi", 1'b1, 4'h0, 4'h0, 8'd0, 1'b1);
    arst_n = 1'b1;
    tick(14);

    // Short lock burst must not release.
    arst_n = 1'b0;
    lock   = 1'b0;
    tick(2);
    arst_n = 1'b1;
    tick(3);
    w = cyc;
    for (int k = 1; k <= 18; k++) push(w + k, "burst", 1'b0, 4'h0, 4'hF, 8'd0, 1'b1);
    push(w + 19, "burst_up", 1'b1, 4'h0, 4'h0, 8'd0, 1'b1);
    lock = 1'b1;
    tick(5);
    lock = 1'b0;
    tick(3);
    lock = 1'b1;
    tick(12);

    for (int k = 0; k < 20 && sb.size() > 0; k++) tick(1);
    while (sb.size() > 0) begin
      exp_t  e;
      string nm;
      e  = sb.pop_front();
      nm = sb_nm.pop_front();
      total++;
      bad++;
      $display("FAIL %s never checked, due cyc=%0d now=%0d", nm, e.cyc, cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
